// File: rtl/pipe_pkg.sv
// Shared pipeline package: ALU opcode fields and
// multiplier FSM state encodings used across stages.
package pipe_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRX = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational EX-stage ALU.
// aluc[3] only matters for the shift group.
module pipe_alu
  import pipe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r
);

  always_comb begin
    r = '0;
    unique case (aluc[2:0])
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_LUI: r = {b[15:0], 16'b0};
      ALU_SLL: r = aluc[3] ? '0
                           : b << a[4:0];
      ALU_SRX: r = aluc[3]
                 ? 32'($signed(b) >>> a[4:0])
                 : b >> a[4:0];
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/pipe_exe_stage.sv
// EX stage: operand muxes, ALU, jal link and a
// 32-cycle shift-add multiplier that stalls the pipe.
module pipe_exe_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [31:0] epc4,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic        ewreg,
  input  logic        ewmem,
  input  logic        emul,
  output logic [31:0] ealu,
  output logic        ewreg_g,
  output logic        ewmem_g,
  output logic        estall,
  output logic        ebusy
);

  mul_state_t  state;
  mul_state_t  nxt;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] r;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  count;

  assign opa = eshift ? {27'b0, eimm[10:6]} : ea;
  assign opb = ealuimm ? eimm : eb;

  pipe_alu u_alu (
    .a    (opa),
    .b    (opb),
    .aluc (ealuc),
    .r    (r)
  );

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) state <= MUL_IDLE;
    else      state <= nxt;
  end

  // Dropping emul mid-multiply is a flush: abort.
  always_comb begin
    nxt = state;
    unique case (state)
      MUL_IDLE: if (emul) nxt = MUL_BUSY;
      MUL_BUSY: begin
        if (!emul)             nxt = MUL_IDLE;
        else if (count == 5'd31) nxt = MUL_DONE;
      end
      MUL_DONE: nxt = MUL_IDLE;
      default:  nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      unique case (state)
        MUL_IDLE: if (emul) begin
          mcand  <= opa;
          mplier <= opb;
          acc    <= '0;
          count  <= '0;
        end
        MUL_BUSY: if (emul) begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign estall  = emul & (state != MUL_DONE);
  assign ebusy   = (state != MUL_IDLE);
  assign ewreg_g = ewreg & ~estall;
  assign ewmem_g = ewmem & ~estall;

  always_comb begin
    if (emul)      ealu = acc;
    else if (ejal) ealu = epc4 + 32'd4;
    else           ealu = r;
  end

endmodule

// File: tb/tb_pipe_exe_stage.sv
// Self-checking bench for pipe_exe_stage: directed
// ALU/jal/MUL cases plus random ALU and MUL traffic.
module tb_pipe_exe_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] ea, eb, eimm, epc4;
  logic [3:0]  ealuc;
  logic        ealuimm, eshift, ejal;
  logic        ewreg, ewmem, emul;
  logic [31:0] ealu;
  logic        ewreg_g, ewmem_g, estall, ebusy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_exe_stage dut (
    .clk     (clk),
    .clrn    (clrn),
    .ea      (ea),
    .eb      (eb),
    .eimm    (eimm),
    .epc4    (epc4),
    .ealuc   (ealuc),
    .ealuimm (ealuimm),
    .eshift  (eshift),
    .ejal    (ejal),
    .ewreg   (ewreg),
    .ewmem   (ewmem),
    .emul    (emul),
    .ealu    (ealu),
    .ewreg_g (ewreg_g),
    .ewmem_g (ewmem_g),
    .estall  (estall),
    .ebusy   (ebusy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    int sh;
    sh = int'(a % 32);
    case (op)
      4'd0, 4'd8:  return a + b;
      4'd4, 4'd12: return a - b;
      4'd1, 4'd9:  return a & b;
      4'd5, 4'd13: return a | b;
      4'd2, 4'd10: return a ^ b;
      4'd6, 4'd14: return b * 32'h10000;
      4'd3:        return b << sh;
      4'd7:        return b >> sh;
      4'd15:       return 32'($signed(b) >>> sh);
      default:     return 32'd0;
    endcase
  endfunction

  // Counts stall cycles until DONE, then checks it.
  task automatic wait_done(input string tag,
                           input logic [31:0] prod,
                           input bit scramble);
    int n;
    int leak;
    n = 0;
    leak = 0;
    while (estall === 1'b1 && n < 100) begin
      if (ewreg_g !== 1'b0 || ewmem_g !== 1'b0)
        leak++;
      n++;
      @(posedge clk); #1;
      if (scramble) begin
        ea = $urandom;
        eb = $urandom;
        eimm = $urandom;
      end
    end
    chk({tag, "_stalls"}, 32'(n), 32'd33);
    chk({tag, "_gated"}, 32'(leak), 32'd0);
    chk({tag, "_prod"}, ealu, prod);
    chk({tag, "_wreg_g"}, {31'b0, ewreg_g}, 32'd1);
    chk({tag, "_busy"}, {31'b0, ebusy}, 32'd1);
    emul = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {31'b0, ebusy}, 32'd0);
  endtask

  task automatic run_mul(input string tag,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input bit scramble);
    ea = x;
    eb = y;
    eshift = 1'b0;
    ealuimm = 1'b0;
    ejal = 1'b0;
    ewreg = 1'b1;
    ewmem = 1'b1;
    emul = 1'b1;
    #1;
    wait_done(tag, x * y, scramble);
  endtask

  initial begin
    logic [31:0] a, b, opa, opb;
    clrn = 1'b1;
    ea = '0; eb = '0; eimm = '0; epc4 = '0;
    ealuc = '0; ealuimm = 1'b0; eshift = 1'b0;
    ejal = 1'b0; ewreg = 1'b0; ewmem = 1'b0;
    emul = 1'b0;
    #1;
    chk("rst_busy", {31'b0, ebusy}, 32'd0);
    chk("rst_stall", {31'b0, estall}, 32'd0);
    chk("rst_ealu", ealu, 32'd0);
    emul = 1'b1;
    #1;
    chk("rst_stall_mul", {31'b0, estall}, 32'd1);
    @(posedge clk); #1;
    chk("rst_hold_idle", {31'b0, ebusy}, 32'd0);
    emul = 1'b0;
    clrn = 1'b0;
    @(posedge clk); #1;

    ea = 32'd5; eb = 32'd7; ealuc = 4'b0000;
    ewreg = 1'b1; ewmem = 1'b0;
    #1;
    chk("add", ealu, 32'd12);
    chk("add_stall", {31'b0, estall}, 32'd0);
    chk("add_wreg_g", {31'b0, ewreg_g}, 32'd1);

    eshift = 1'b1;
    eimm = 32'd4 << 6;
    eb = 32'h8000_0000;
    ealuc = 4'b1111;
    #1;
    chk("sra", ealu, 32'hF800_0000);
    eshift = 1'b0;

    ejal = 1'b1;
    epc4 = 32'h0000_0100;
    #1;
    chk("jal", ealu, 32'h0000_0104);
    ejal = 1'b0;

    ealuc = 4'b1011;
    ea = 32'h1234; eb = 32'h5678;
    #1;
    chk("undef", ealu, 32'd0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      ea = a;
      eb = b;
      eimm = $urandom;
      ealuc = 4'($urandom_range(0, 15));
      eshift = 1'($urandom);
      ealuimm = 1'($urandom);
      ewreg = 1'($urandom);
      ewmem = 1'($urandom);
      #1;
      opa = eshift ? 32'((eimm >> 6) % 32) : a;
      opb = ealuimm ? eimm : b;
      chk("alu_rand", ealu,
          alu_ref(ealuc, opa, opb));
      chk("wmem_rand", {31'b0, ewmem_g},
          {31'b0, ewmem});
      @(posedge clk); #1;
    end
    eshift = 1'b0;
    ealuimm = 1'b0;

    run_mul("mul_6x7", 32'd6, 32'd7, 1'b0);
    run_mul("mul_ffx2", 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_mul("mul_64k", 32'h1_0000, 32'h1_0000, 1'b0);
    for (int i = 0; i < 4; i++)
      run_mul("mul_rand", $urandom, $urandom, 1'b1);

    ea = 32'd9; eb = 32'd9; emul = 1'b1;
    ewreg = 1'b1;
    #1;
    repeat (5) @(posedge clk);
    #1;
    emul = 1'b0;
    #1;
    chk("flush_stall", {31'b0, estall}, 32'd0);
    chk("flush_wreg_g", {31'b0, ewreg_g}, 32'd1);
    @(posedge clk); #1;
    chk("flush_idle", {31'b0, ebusy}, 32'd0);

    ea = 32'd6; eb = 32'd7; emul = 1'b1;
    #1;
    repeat (11) @(posedge clk);
    #1;
    chk("rst_mid_busy", {31'b0, ebusy}, 32'd1);
    clrn = 1'b1;
    #1;
    chk("rst_mid_idle", {31'b0, ebusy}, 32'd0);
    chk("rst_mid_stall", {31'b0, estall}, 32'd1);
    chk("rst_mid_acc", ealu, 32'd0);
    clrn = 1'b0;
    #1;
    wait_done("mul_after_rst", 32'd42, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_exe_stage.md
PIPE_EXE_STAGE -- requirements
Module: pipe_exe_stage

Interface
REQ-001 The block SHALL use reset clrn, asynchronous, active-high, and clock clk.
REQ-002 Ports SHALL be as follows:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-high reset.
- ea, eb  in  32  register operands from the ID/EX register.
- eimm  in  32  extended immediate; shift amount in eimm[10:6].
- epc4  in  32  PC+4 of the instruction in EX.
- ealuc  in  4  ALU operation code.
- ealuimm, eshift, ejal  in  1  operand-B select, operand-A select and jal select.
- ewreg, ewmem  in  1  register-write and memory-write enables.
- emul  in  1  instruction is a MUL (low 32 bits of the product).
- ealu  out  32  EX result to the EX/MEM register.
- ewreg_g, ewmem_g  out  1  enables gated by the stall.
- estall  out  1  freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- ebusy  out  1  multiplier FSM not in IDLE.

Function
REQ-003 Operand A SHALL be {27'b0, eimm[10:6]} when eshift=1, else ea.
REQ-004 Operand B SHALL be eimm when ealuimm=1, else eb.
REQ-005 ALU opcodes SHALL be:
- x000 add, x100 sub (32-bit wrap, no overflow trap).
- x001 and, x101 or, x010 xor.
- x110 lui: {B[15:0],16'b0}.
- 0011 sll, 0111 srl, 1111 sra: B shifted by A[4:0].
- Undefined codes SHALL yield 0.
REQ-006 When emul=0, ealu SHALL be epc4+4 if ejal=1, else the ALU result; this path SHALL be combinational with zero latency.
REQ-007 The multiplier SHALL be a 3-state FSM: IDLE, BUSY, DONE.
REQ-008 In IDLE with emul=1, the FSM SHALL load mcand=A, mplier=B, acc=0, count=0, then go to BUSY.
REQ-009 Each BUSY cycle SHALL:
- add mcand to acc when mplier[0]=1;
- shift mcand left 1 and mplier right 1;
- increment count.
REQ-010 After the iteration with count=31, the FSM SHALL go to DONE; in DONE it SHALL return to IDLE on the next edge.
REQ-011 estall SHALL equal emul AND (state != DONE), combinationally; a MUL therefore stalls exactly 33 cycles (1 IDLE + 32 BUSY) and completes in the DONE cycle.
REQ-012 When emul=1, ealu SHALL be acc (low 32 bits; signed and unsigned results are identical).
REQ-013 ewreg_g SHALL equal ewreg AND NOT estall; ewmem_g SHALL equal ewmem AND NOT estall.
REQ-014 If emul falls while in BUSY (flush), the FSM SHALL abort to IDLE on the next edge and no result is produced.
REQ-015 ejal and emul both high is illegal; emul SHALL take priority.
REQ-016 Operands are captured at the IDLE->BUSY edge; later changes on ea/eb/eimm SHALL NOT affect the product.
REQ-017 ebusy SHALL be 1 in BUSY and DONE, else 0.

Reset
REQ-018 When clrn=1, state SHALL be IDLE, and acc, mcand, mplier and count SHALL be 0, immediately and independent of clk.
REQ-019 During reset, estall SHALL equal emul and ebusy SHALL be 0.
REQ-020 A reset mid-BUSY SHALL discard the partial product; if emul is still 1 after reset, a fresh 33-cycle multiply SHALL start.

Structure
REQ-021 The ALU opcode constants and the FSM state encodings SHALL live in the shared pipeline package used by all pipeline stages.
REQ-022 The ALU SHALL be a combinational sub-module named pipe_alu (inputs a, b, aluc; output r).
REQ-023 The FSM and datapath registers SHALL reside in pipe_exe_stage; no other sub-modules are required.

Verification
REQ-024 Add: ea=5, eb=7, ealuc=0000, emul=0 -> ealu=12 same cycle; estall=0; ewreg_g=ewreg.
REQ-025 Sra: eshift=1, eimm[10:6]=4, eb=0x80000000, ealuc=1111 -> ealu=0xF8000000.
REQ-026 Jal: ejal=1, epc4=0x00000100 -> ealu=0x00000104.
REQ-027 MUL 6*7 held stable -> estall=1 and ewreg_g=0 for 33 cycles, then DONE with estall=0, ealu=42, ewreg_g=1, then IDLE.
REQ-028 MUL 0xFFFFFFFF*2 -> ealu=0xFFFFFFFE in DONE; MUL 0x10000*0x10000 -> 0x00000000.
REQ-029 Asynchronous clrn pulse during BUSY cycle 10 -> state IDLE immediately; with emul held at 1, DONE arrives 33 cycles after clrn falls, with the correct product.
